// File: rtl/axis_pattern_gen.sv
// rtl/axis_pattern_gen.sv - AXI-Stream test pattern generator (ramp, constant, toggle, PRBS31)
//
// Purpose: emits bursts of multi-lane samples on an AXI-Stream master port.
// A start pulse latches the configuration and begins a burst; the burst ends
// on the sample that completes cfg_length acceptances, or on a stop pulse.
//
// Ports:
//   aclk, areset              clock, asynchronous active-high reset
//   cfg_mode                  0=ramp, 1=constant, 2=toggle, 3=PRBS31
//   cfg_step                  ramp increment, or constant/toggle value
//   cfg_length                samples per burst, 0 = continuous
//   cfg_drop                  1 = free-running (drop under backpressure), 0 = stall
//   start, stop               single-cycle control pulses (stop wins)
//   m_axis_tdata/tvalid/tready/tlast  stream output, lane k at [k*DATA_WIDTH +: DATA_WIDTH]
//   sts_count                 samples accepted in the current or last burst
//   sts_drops                 samples discarded under backpressure
//   busy                      high while running a burst
module axis_pattern_gen #(
   parameter int CHANNELS   = 2,
   parameter int DATA_WIDTH = 16
) (
   input  logic                           aclk,
   input  logic                           areset,
   input  logic [1:0]                     cfg_mode,
   input  logic [DATA_WIDTH-1:0]          cfg_step,
   input  logic [31:0]                    cfg_length,
   input  logic                           cfg_drop,
   input  logic                           start,
   input  logic                           stop,
   output logic [CHANNELS*DATA_WIDTH-1:0] m_axis_tdata,
   output logic                           m_axis_tvalid,
   input  logic                           m_axis_tready,
   output logic                           m_axis_tlast,
   output logic [31:0]                    sts_count,
   output logic [31:0]                    sts_drops,
   output logic                           busy
);

   localparam int TW = CHANNELS * DATA_WIDTH;
   localparam logic [30:0] LFSR_SEED = 31'h7FFF_FFFF;

   typedef enum logic {ST_IDLE, ST_RUN} state_t;

   state_t                state_q, state_d;
   logic [1:0]            mode_q, mode_d;
   logic [DATA_WIDTH-1:0] step_q, step_d;
   logic [31:0]           length_q, length_d;
   logic                  drop_q, drop_d;
   logic [DATA_WIDTH-1:0] acc_q, acc_d;
   logic [30:0]           lfsr_q, lfsr_d;
   logic                  tog_q, tog_d;
   logic [TW-1:0]         tdata_q, tdata_d;
   logic                  tvalid_q, tvalid_d;
   logic                  tlast_q, tlast_d;
   logic [31:0]           count_q, count_d;
   logic [31:0]           drops_q, drops_d;

   logic                  accept;
   logic [TW-1:0]         start_sample;
   logic [TW-1:0]         run_sample;

   // x^31 + x^28 + 1, shifting left with the feedback bit entering at bit 0
   function automatic logic [30:0] lfsr_next(input logic [30:0] s);
      return {s[29:0], s[30] ^ s[27]};
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // Builds one multi-lane sample from the generator state.
   function automatic logic [TW-1:0] gen_sample(
      input logic [1:0]            mode,
      input logic [DATA_WIDTH-1:0] step,
      input logic [DATA_WIDTH-1:0] acc,
      input logic [30:0]           lfsr,
      input logic                  tog
   );
      logic [TW-1:0]         s;
      logic [DATA_WIDTH-1:0] lane;
      logic [31:0]           prbs_ext;
      logic [DATA_WIDTH-1:0] prbs;
      s        = '0;
      lane     = acc;
      prbs_ext = {1'b0, lfsr};
      prbs     = prbs_ext[DATA_WIDTH-1:0];
      for (int k = 0; k < CHANNELS; k++) begin
         case (mode)
            2'd0:    s[k*DATA_WIDTH +: DATA_WIDTH] = lane;
            2'd1:    s[k*DATA_WIDTH +: DATA_WIDTH] = step;
            2'd2:    s[k*DATA_WIDTH +: DATA_WIDTH] = tog ? ~step : step;
            default: s[k*DATA_WIDTH +: DATA_WIDTH] = ((k % 2) == 1) ? ~prbs : prbs;
         endcase
         lane = lane + step;
      end
      return s;
   endfunction

   assign accept       = tvalid_q & m_axis_tready;
   // First sample of a burst comes from the live config and the reset generator state.
   assign start_sample = gen_sample(cfg_mode, cfg_step, '0, LFSR_SEED, 1'b0);
   assign run_sample   = gen_sample(mode_q, step_q, acc_q, lfsr_q, tog_q);

   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      step_d   = step_q;
      length_d = length_q;
      drop_d   = drop_q;
      acc_d    = acc_q;
      lfsr_d   = lfsr_q;
      tog_d    = tog_q;
      tdata_d  = tdata_q;
      tvalid_d = tvalid_q;
      tlast_d  = tlast_q;
      count_d  = count_q;
      drops_d  = drops_q;

      case (state_q)
         ST_IDLE: begin
            if (start && !stop) begin
               state_d  = ST_RUN;
               mode_d   = cfg_mode;
               step_d   = cfg_step;
               length_d = cfg_length;
               drop_d   = cfg_drop;
               count_d  = '0;
               drops_d  = '0;
               // Generator state already advanced past the sample being presented
               tdata_d  = start_sample;
               acc_d    = cfg_step;
               lfsr_d   = lfsr_next(LFSR_SEED);
               tog_d    = 1'b1;
               tvalid_d = 1'b1;
               tlast_d  = (cfg_length == 32'd1);
            end
         end
         ST_RUN: begin
            if (accept) begin
               count_d = sat_inc(count_q);
            end
            if (stop) begin
               state_d  = ST_IDLE;
               tvalid_d = 1'b0;
               tlast_d  = 1'b0;
            end else if (accept && tlast_q) begin
               state_d  = ST_IDLE;
               tvalid_d = 1'b0;
               tlast_d  = 1'b0;
            end else if (accept || drop_q) begin
               acc_d  = acc_q + step_q;
               lfsr_d = lfsr_next(lfsr_q);
               tog_d  = ~tog_q;
               if (accept) begin
                  tdata_d = run_sample;
                  tlast_d = (length_q != 32'd0) &&
                            (({1'b0, count_d} + 33'd1) == {1'b0, length_q});
               end else begin
                  // Output slot still occupied: the fresh sample is lost
                  drops_d = sat_inc(drops_q);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_q  <= ST_IDLE;
         mode_q   <= '0;
         step_q   <= '0;
         length_q <= '0;
         drop_q   <= 1'b0;
         acc_q    <= '0;
         lfsr_q   <= LFSR_SEED;
         tog_q    <= 1'b0;
         tdata_q  <= '0;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
         count_q  <= '0;
         drops_q  <= '0;
      end else begin
         state_q  <= state_d;
         mode_q   <= mode_d;
         step_q   <= step_d;
         length_q <= length_d;
         drop_q   <= drop_d;
         acc_q    <= acc_d;
         lfsr_q   <= lfsr_d;
         tog_q    <= tog_d;
         tdata_q  <= tdata_d;
         tvalid_q <= tvalid_d;
         tlast_q  <= tlast_d;
         count_q  <= count_d;
         drops_q  <= drops_d;
      end
   end

   assign m_axis_tdata  = tdata_q;
   assign m_axis_tvalid = tvalid_q;
   assign m_axis_tlast  = tlast_q;
   assign sts_count     = count_q;
   assign sts_drops     = drops_q;
   assign busy          = (state_q == ST_RUN);

endmodule

// File: tb/tb_axis_pattern_gen.sv
// tb/tb_axis_pattern_gen.sv - self-checking bench for axis_pattern_gen
module tb_axis_pattern_gen;

   localparam int CH    = 2;
   localparam int DW    = 16;
   localparam int TW    = CH * DW;
   localparam int BOUND = 3000;

   logic          aclk = 1'b0;
   logic          areset;
   logic [1:0]    cfg_mode;
   logic [DW-1:0] cfg_step;
   logic [31:0]   cfg_length;
   logic          cfg_drop;
   logic          start;
   logic          stop;
   logic [TW-1:0] m_axis_tdata;
   logic          m_axis_tvalid;
   logic          m_axis_tready;
   logic          m_axis_tlast;
   logic [31:0]   sts_count;
   logic [31:0]   sts_drops;
   logic          busy;

   int n_tests = 0;
   int n_fail  = 0;

   bit            prbs_b [0:8191];
   logic [DW-1:0] rec_l0[$];
   logic [DW-1:0] rec_l1[$];
   logic          rec_last[$];

   axis_pattern_gen #(.CHANNELS(CH), .DATA_WIDTH(DW)) dut (
      .aclk(aclk), .areset(areset), .cfg_mode(cfg_mode), .cfg_step(cfg_step),
      .cfg_length(cfg_length), .cfg_drop(cfg_drop), .start(start), .stop(stop),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
      .sts_count(sts_count), .sts_drops(sts_drops), .busy(busy)
   );

   always #5 aclk = ~aclk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Sample n of the stream, lane k, from the pattern definitions.
   function automatic logic [DW-1:0] exp_lane(input logic [1:0] mode, input logic [DW-1:0] stp,
                                              input int n, input int k);
      logic [63:0]   t;
      logic [DW-1:0] v;
      case (mode)
         2'd0: begin
            t = 64'(n + k) * 64'(stp);
            v = t[DW-1:0];
         end
         2'd1: v = stp;
         2'd2: v = ((n % 2) == 1) ? ~stp : stp;
         default: begin
            // bit i of the register after n steps is sequence bit 30+n-i
            for (int i = 0; i < DW; i++) v[i] = (i < 31) ? prbs_b[30 + n - i] : 1'b0;
            if ((k % 2) == 1) v = ~v;
         end
      endcase
      return v;
   endfunction

   task automatic run_burst(input logic [1:0] mode, input logic [DW-1:0] stp, input int len,
                            input logic drop, input int pct, input int stall_at,
                            input int stall_len, input int stop_after);
      int            p, g, cnt, drops, cyc;
      bit            running, acc, last_e, stop_now;
      logic [TW-1:0] ev;
      rec_l0.delete(); rec_l1.delete(); rec_last.delete();
      cfg_mode = mode; cfg_step = stp; cfg_length = 32'(len); cfg_drop = drop;
      start = 1'b1; stop = 1'b0; m_axis_tready = 1'b0;
      @(posedge aclk); #1;
      start = 1'b0;
      p = 0; g = 1; cnt = 0; drops = 0; cyc = 0; running = 1'b1;
      while (running && cyc < BOUND) begin
         stop_now = (stop_after > 0) && (cnt == stop_after);
         if (stop_now) m_axis_tready = 1'b0;
         else if (cyc >= stall_at && cyc < stall_at + stall_len) m_axis_tready = 1'b0;
         else m_axis_tready = ($urandom_range(99) < pct);
         stop  = stop_now;
         start = stop_now | ($urandom_range(7) == 0);
         cfg_mode = 2'($urandom); cfg_step = DW'($urandom);
         cfg_length = $urandom; cfg_drop = 1'($urandom);
         for (int k = 0; k < CH; k++) ev[k*DW +: DW] = exp_lane(mode, stp, p, k);
         last_e = (len != 0) && (cnt + 1 == len);
         chk("run tvalid", 64'(m_axis_tvalid), 64'(1));
         chk("run busy", 64'(busy), 64'(1));
         chk("run tdata", 64'(m_axis_tdata), 64'(ev));
         chk("run tlast", 64'(m_axis_tlast), 64'(last_e));
         chk("run sts_count", 64'(sts_count), 64'(cnt));
         acc = m_axis_tready;
         if (acc) begin
            rec_l0.push_back(m_axis_tdata[DW-1:0]);
            rec_l1.push_back(m_axis_tdata[2*DW-1:DW]);
            rec_last.push_back(m_axis_tlast);
            cnt++;
         end
         if (stop_now) running = 1'b0;
         else if (acc && last_e) running = 1'b0;
         else if (acc) begin p = g; g++; end
         else if (drop) begin g++; drops++; end
         @(posedge aclk); #1;
         cyc++;
         start = 1'b0; stop = 1'b0;
      end
      chk("burst ended in bound", 64'(running), 64'(0));
      chk("end tvalid", 64'(m_axis_tvalid), 64'(0));
      chk("end tlast", 64'(m_axis_tlast), 64'(0));
      chk("end busy", 64'(busy), 64'(0));
      chk("end sts_count", 64'(sts_count), 64'(cnt));
      chk("end sts_drops", 64'(sts_drops), 64'(drops));
      m_axis_tready = 1'b0;
   endtask

   typedef struct {
      logic [1:0]    mode;
      logic [DW-1:0] stp;
      int            len;
      int            idx;
      logic [DW-1:0] l0;
      logic [DW-1:0] l1;
      logic          last;
   } vec_t;

   vec_t vt[12];

   initial begin
      vt[0]  = '{2'd0, 16'd64,    4, 0, 16'd0,    16'd64,   1'b0};
      vt[1]  = '{2'd0, 16'd64,    4, 3, 16'd192,  16'd256,  1'b1};
      vt[2]  = '{2'd0, 16'h4000,  6, 2, 16'h8000, 16'hC000, 1'b0};
      vt[3]  = '{2'd0, 16'h4000,  6, 4, 16'h0000, 16'h4000, 1'b0};
      vt[4]  = '{2'd0, 16'h4000,  6, 5, 16'h4000, 16'h8000, 1'b1};
      vt[5]  = '{2'd1, 16'h1234,  3, 1, 16'h1234, 16'h1234, 1'b0};
      vt[6]  = '{2'd2, 16'h00FF,  3, 1, 16'hFF00, 16'hFF00, 1'b0};
      vt[7]  = '{2'd2, 16'h00FF,  3, 2, 16'h00FF, 16'h00FF, 1'b1};
      vt[8]  = '{2'd3, 16'h0000,  3, 0, 16'hFFFF, 16'h0000, 1'b0};
      vt[9]  = '{2'd3, 16'h0000,  3, 1, 16'hFFFE, 16'h0001, 1'b0};
      vt[10] = '{2'd3, 16'h0000,  3, 2, 16'hFFFC, 16'h0003, 1'b1};
      vt[11] = '{2'd0, 16'd5,     1, 0, 16'd0,    16'd5,    1'b1};

      for (int i = 0; i < 31; i++) prbs_b[i] = 1'b1;
      for (int m = 31; m < 8192; m++) prbs_b[m] = prbs_b[m-31] ^ prbs_b[m-28];

      areset = 1'b1; cfg_mode = '0; cfg_step = '0; cfg_length = '0; cfg_drop = 1'b0;
      start = 1'b0; stop = 1'b0; m_axis_tready = 1'b0;
      repeat (3) @(posedge aclk);
      #1;
      chk("reset tvalid", 64'(m_axis_tvalid), 64'(0));
      chk("reset tdata", 64'(m_axis_tdata), 64'(0));
      chk("reset busy", 64'(busy), 64'(0));
      chk("reset sts_count", 64'(sts_count), 64'(0));
      areset = 1'b0;
      @(posedge aclk); #1;

      // start and stop together in IDLE: stop wins
      start = 1'b1; stop = 1'b1;
      @(posedge aclk); #1;
      start = 1'b0; stop = 1'b0;
      @(posedge aclk); #1;
      chk("start+stop idle busy", 64'(busy), 64'(0));
      chk("start+stop idle tvalid", 64'(m_axis_tvalid), 64'(0));

      // table-driven bursts with tready held high
      for (int i = 0; i < 12; i++) begin
         run_burst(vt[i].mode, vt[i].stp, vt[i].len, 1'b0, 100, 0, 0, 0);
         if (vt[i].idx < rec_l0.size()) begin
            chk($sformatf("vec%0d lane0", i), 64'(rec_l0[vt[i].idx]), 64'(vt[i].l0));
            chk($sformatf("vec%0d lane1", i), 64'(rec_l1[vt[i].idx]), 64'(vt[i].l1));
            chk($sformatf("vec%0d tlast", i), 64'(rec_last[vt[i].idx]), 64'(vt[i].last));
         end else begin
            chk($sformatf("vec%0d sample count", i), 64'(rec_l0.size()), 64'(vt[i].idx + 1));
         end
      end

      // stall mode: 5 low-ready cycles mid-burst, nothing skipped or dropped
      run_burst(2'd0, 16'd7, 8, 1'b0, 100, 3, 5, 0);
      chk("stall count", 64'(rec_l0.size()), 64'(8));
      for (int i = 0; i < 8 && i < rec_l0.size(); i++)
         chk($sformatf("stall lane0 s%0d", i), 64'(rec_l0[i]), 64'(i * 7));
      chk("stall drops", 64'(sts_drops), 64'(0));

      // drop mode: sample 2 held for 3 cycles, then the newest (6) follows
      run_burst(2'd0, 16'd1, 5, 1'b1, 100, 2, 3, 0);
      chk("drop count", 64'(rec_l0.size()), 64'(5));
      if (rec_l0.size() >= 4) begin
         chk("drop held sample", 64'(rec_l0[2]), 64'(2));
         chk("drop next sample", 64'(rec_l0[3]), 64'(6));
      end
      chk("drop sts_drops", 64'(sts_drops), 64'(3));

      // continuous PRBS stopped after 100 accepts
      run_burst(2'd3, 16'h5A5A, 0, 1'b0, 100, 0, 0, 100);
      chk("prbs count", 64'(sts_count), 64'(100));
      if (rec_l0.size() > 0) begin
         chk("prbs first lane0", 64'(rec_l0[0]), 64'(16'hFFFF));
         chk("prbs first lane1", 64'(rec_l1[0]), 64'(16'h0000));
      end
      begin
         int nl = 0;
         foreach (rec_last[i]) if (rec_last[i]) nl++;
         chk("prbs no tlast", 64'(nl), 64'(0));
      end

      // asynchronous reset mid-burst
      cfg_mode = 2'd0; cfg_step = 16'd3; cfg_length = 32'd0; cfg_drop = 1'b0;
      start = 1'b1; m_axis_tready = 1'b1;
      @(posedge aclk); #1;
      start = 1'b0;
      repeat (4) @(posedge aclk);
      #3;
      areset = 1'b1;
      #1;
      chk("async rst tvalid", 64'(m_axis_tvalid), 64'(0));
      chk("async rst tdata", 64'(m_axis_tdata), 64'(0));
      chk("async rst tlast", 64'(m_axis_tlast), 64'(0));
      chk("async rst busy", 64'(busy), 64'(0));
      chk("async rst sts_count", 64'(sts_count), 64'(0));
      chk("async rst sts_drops", 64'(sts_drops), 64'(0));
      @(posedge aclk); #1;
      areset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge aclk); #1;
         chk("post reset idle tvalid", 64'(m_axis_tvalid), 64'(0));
      end
      m_axis_tready = 1'b0;
      run_burst(2'd1, 16'h1234, 4, 1'b0, 100, 0, 0, 0);
      chk("const count", 64'(rec_l0.size()), 64'(4));
      foreach (rec_l0[i]) begin
         chk("const lane0", 64'(rec_l0[i]), 64'(16'h1234));
         chk("const lane1", 64'(rec_l1[i]), 64'(16'h1234));
      end

      // randomized bursts against the model
      for (int b = 0; b < 25; b++) begin
         int len, sa;
         len = ($urandom_range(5) == 0) ? 0 : int'($urandom_range(40, 1));
         if (len == 0) sa = int'($urandom_range(30, 1));
         else sa = ($urandom_range(4) == 0) ? int'($urandom_range(len, 1)) : 0;
         run_burst(2'($urandom), DW'($urandom), len, 1'($urandom),
                   int'($urandom_range(100, 30)), 0, 0, sa);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/axis_pattern_gen.md
AXIS_PATTERN_GEN -- requirements
Module: axis_pattern_gen

Interface
REQ-001 The block SHALL have the parameter CHANNELS, default 2, giving the number of parallel sample lanes (1..8).
REQ-002 The block SHALL have the parameter DATA_WIDTH, default 16, giving the bits per lane (8..32).
REQ-003 The block SHALL have the port aclk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have the port areset, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have the port cfg_mode, input, 2, selecting 0=ramp, 1=constant, 2=toggle, 3=PRBS31.
REQ-006 The block SHALL have the port cfg_step, input, DATA_WIDTH, giving the ramp increment or the constant/toggle value.
REQ-007 The block SHALL have the port cfg_length, input, 32, giving samples per burst, where 0 means continuous.
REQ-008 The block SHALL have the port cfg_drop, input, 1, selecting 1=free-running ADC emulation or 0=stall on backpressure.
REQ-009 The block SHALL have the port start, input, 1, a single-cycle pulse that starts a burst.
REQ-010 The block SHALL have the port stop, input, 1, a single-cycle pulse that aborts a burst.
REQ-011 The block SHALL have the ports m_axis_tdata (output, CHANNELS*DATA_WIDTH; lane k at bits [k*DATA_WIDTH +: DATA_WIDTH]), m_axis_tvalid (output, 1), m_axis_tready (input, 1) and m_axis_tlast (output, 1).
REQ-012 The block SHALL have the port sts_count, output, 32, counting samples accepted in the current or last burst.
REQ-013 The block SHALL have the port sts_drops, output, 32, counting samples discarded under backpressure.
REQ-014 The block SHALL have the port busy, output, 1, high while in the RUN state.

Function
REQ-015 The state machine SHALL have the states IDLE and RUN; start in IDLE moves to RUN; start in RUN is ignored.
REQ-016 On start, the block SHALL latch cfg_mode, cfg_step, cfg_length and cfg_drop, clear sts_count and sts_drops, clear the accumulator to 0 and seed the LFSR to 0x7FFFFFFF; config changes during RUN SHALL have no effect.
REQ-017 The first sample SHALL be presented with m_axis_tvalid high on the cycle after the start cycle.
REQ-018 A sample SHALL be accepted on any cycle where tvalid and tready are both high; sts_count increments by 1 on each acceptance, saturating at 0xFFFFFFFF.
REQ-019 Ramp mode: the accumulator SHALL advance by cfg_step per generated sample, and lane k SHALL equal acc + k*cfg_step, modulo 2^DATA_WIDTH (wrap, no saturation).
REQ-020 Constant mode: every lane SHALL equal cfg_step on every sample.
REQ-021 Toggle mode: every lane SHALL alternate cfg_step and ~cfg_step, starting with cfg_step.
REQ-022 PRBS31 mode: the LFSR (x^31+x^28+1) SHALL advance one step per generated sample; lane k SHALL be LFSR[DATA_WIDTH-1:0], bitwise inverted for odd k (for DATA_WIDTH>31, zero-extended).
REQ-023 If cfg_drop=0, the generator SHALL advance only on acceptance, and tdata/tlast SHALL be held stable while tvalid high and tready low.
REQ-024 If cfg_drop=1, the generator SHALL advance every RUN cycle; while tvalid high and tready low, the presented sample SHALL be held and each newly generated sample SHALL be discarded, incrementing sts_drops (saturating); after tready returns, the next presented sample SHALL be the newest generated one.
REQ-025 For a finite burst, m_axis_tlast SHALL be high on the sample whose acceptance makes sts_count equal cfg_length; on that acceptance the block SHALL return to IDLE with tvalid low the next cycle.
REQ-026 For cfg_length=0, tlast SHALL never assert, and RUN SHALL continue until stop.
REQ-027 A stop pulse in RUN SHALL force IDLE on the next cycle, with tvalid low, tlast low and any held sample abandoned; sts_count and sts_drops SHALL be retained.
REQ-028 If start and stop are both high in the same cycle, stop SHALL win: in IDLE nothing happens, and in RUN the burst aborts.
REQ-029 busy SHALL equal (state==RUN).

Reset
REQ-030 areset SHALL asynchronously force IDLE, tvalid=0, tlast=0, tdata=0, busy=0, sts_count=0, sts_drops=0, accumulator=0 and LFSR=0x7FFFFFFF; assertion mid-burst SHALL abandon the burst without a tlast.
REQ-031 After reset deassertion, no sample SHALL be output until a start pulse.

Verification
REQ-032 Ramp, CHANNELS=2, step=64, length=4, tready=1 -> lane0 0,64,128,192; lane1 64,128,192,256; tlast on the 4th sample; busy falls; sts_count=4.
REQ-033 Ramp, step=0x4000, DATA_WIDTH=16, length=6 -> lane0 0,0x4000,0x8000,0xC000,0x0000,0x4000 (wrap).
REQ-034 Ramp, cfg_drop=0, tready low 5 cycles mid-burst -> tdata stable throughout, no sample skipped, sts_drops=0.
REQ-035 Ramp, cfg_drop=1, step=1, tready low 3 cycles while sample 2 held -> 2 accepted, then 6 next, sts_drops=3.
REQ-036 PRBS31, length=0, stop after 100 accepts -> first lane0 value 0xFFFF (16-bit), lane1 0x0000; tvalid low the cycle after stop; sts_count=100; no tlast.
REQ-037 areset pulse mid-burst, then start with mode=constant, step=0x1234 -> all outputs 0 during reset; afterwards all lanes 0x1234.
